// File: rtl/conv3x3_pkg.sv
// Shared constants and helpers for the streaming 3x3 convolution engine.
package conv3x3_pkg;

  localparam int KTAPS   = 9;  // 3x3 kernel, row-major, index 0 = top-left
  localparam int KCENTER = 4;  // centre tap of the kernel
  localparam int SAT_W   = 64; // working width of the saturation helper

  // Accumulator width for the sum of nine signed products.
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 5;
  endfunction

  // Clamp a signed value to the unsigned pixel range [0, 2^data_w-1].
  function automatic logic [31:0] saturate(input logic signed [SAT_W-1:0] v,
                                           input int data_w);
    logic signed [SAT_W-1:0] max_v;
    max_v = (64'sd1 <<< data_w) - 64'sd1;
    if (v < 0) begin
      return '0;
    end else if (v > max_v) begin
      return max_v[31:0];
    end else begin
      return v[31:0];
    end
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: combinational read and registered write at
// the same address, so a read returns the value from the previous line.
module line_buffer #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  // Store the incoming pixel for the current column on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is cleared on reset so that no stale line from an
      // aborted frame can leak into the first window after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: raster pixels in, one saturated result per
// interior window position out, with full valid/ready backpressure.
module conv3x3_stream
  import conv3x3_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 16,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_eol
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic signed [COEF_W-1:0] K_UNITY = COEF_W'(1 << SHIFT);

  typedef logic signed [COEF_W-1:0] kernel_t [KTAPS];

  logic                     advance;
  logic                     accept;
  logic [CW-1:0]            col_q, col_d, col_cur;
  logic [1:0]               row_q, row_d, row_cur;
  logic [DATA_W-1:0]        lb0_rd, lb1_rd;
  logic [DATA_W-1:0]        win_q [3][3];
  logic [DATA_W-1:0]        win_d [3][3];
  logic                     v0_q, v0_d, eol0_q, eol0_d;
  kernel_t                  coef_q, coef_d;
  logic signed [PROD_W-1:0] prod_q [KTAPS];
  logic signed [PROD_W-1:0] prod_d [KTAPS];
  logic signed [PROD_W-1:0] px_ext, cf_ext;
  logic                     v1_q, v1_d, eol1_q, eol1_d;
  logic signed [ACC_W-1:0]  sum, shifted;
  logic [DATA_W-1:0]        m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d, m_eol_q, m_eol_d;

  // The whole pipeline moves together; it freezes only while a result waits.
  assign advance = !(m_valid_q && !m_ready);
  assign accept  = s_valid && advance;
  assign s_ready = advance;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_eol   = m_eol_q;

  // Raster position of the beat being offered; a start-of-frame forces (0,0).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    col_cur = s_sof ? '0 : col_q;
    row_cur = s_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == 2'd2) ? row_cur : row_cur + 2'd1;
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  // Two stacked line buffers supply the two older rows of the new column.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .ADDR_W(CW)) u_lb0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (accept),
    .addr_i    (col_cur),
    .wr_data_i (s_data),
    .rd_data_o (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .ADDR_W(CW)) u_lb1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (accept),
    .addr_i    (col_cur),
    .wr_data_i (lb0_rd),
    .rd_data_o (lb1_rd)
  );

  // E0: shift the window left and tag the beat; bubbles become invalid tags.
  always_comb begin
    win_d  = win_q;
    v0_d   = v0_q;
    eol0_d = eol0_q;
    if (advance) begin
      v0_d   = accept && (row_cur == 2'd2) && (col_cur >= CW'(2));
      eol0_d = v0_d && (col_cur == COL_LAST);
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_d[r][0] = win_q[r][1];
          win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb1_rd;
        win_d[1][2] = lb0_rd;
        win_d[2][2] = s_data;
      end
    end
  end

  // Coefficient file: in-range writes update one tap, others are dropped.
  always_comb begin
    coef_d = coef_q;
    if (cfg_we && (cfg_addr < 4'd9)) begin
      coef_d[cfg_addr] = cfg_data;
    end
  end

  // E1: nine signed products of zero-extended pixels and kernel taps.
  always_comb begin
    prod_d = prod_q;
    px_ext = '0;
    cf_ext = '0;
    v1_d   = v1_q;
    eol1_d = eol1_q;
    if (advance) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          px_ext = {{(PROD_W-DATA_W){1'b0}}, win_q[r][c]};
          cf_ext = {{(PROD_W-COEF_W){coef_q[r*3+c][COEF_W-1]}}, coef_q[r*3+c]};
          prod_d[r*3+c] = px_ext * cf_ext;
        end
      end
      v1_d   = v0_q;
      eol1_d = eol0_q;
    end
  end

  // E2: accumulate, arithmetic shift, clamp to the unsigned pixel range.
  always_comb begin
    sum = '0;
    for (int i = 0; i < KTAPS; i++) begin
      sum = sum + {{(ACC_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
    end
    shifted   = sum >>> SHIFT;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_eol_d   = m_eol_q;
    if (advance) begin
      m_data_d  = DATA_W'(saturate({{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted},
                                   DATA_W));
      m_valid_d = v1_q;
      m_eol_d   = eol1_q;
    end
  end

  // State registers; reset discards in-flight results and restores identity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      v0_q   <= 1'b0;
      eol0_q <= 1'b0;
      v1_q   <= 1'b0;
      eol1_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      for (int i = 0; i < KTAPS; i++) begin
        coef_q[i] <= (i == KCENTER) ? K_UNITY : '0;
        prod_q[i] <= '0;
      end
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_eol_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from
      // before this edge, independent of statement order.
      col_q     <= col_d;
      row_q     <= row_d;
      win_q     <= win_d;
      v0_q      <= v0_d;
      eol0_q    <= eol0_d;
      coef_q    <= coef_d;
      prod_q    <= prod_d;
      v1_q      <= v1_d;
      eol1_q    <= eol1_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_eol_q   <= m_eol_d;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 4-pixel-wide image.
module tb_conv3x3_stream;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int IMG_W  = 4;
  localparam int SHIFT  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_addr = '0;
  logic [COEF_W-1:0] cfg_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_sof = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic              m_eol;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int out_d[$];
  int out_e[$];
  int out_c[$];
  int acc_edge[$];

  conv3x3_stream #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .SHIFT(SHIFT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sof    (s_sof),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_eol    (m_eol)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every result that will be handshaken at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      out_d.push_back(int'(m_data));
      out_e.push_back(int'(m_eol));
      out_c.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  task automatic clear_logs();
    out_d.delete();
    out_e.delete();
    out_c.delete();
    acc_edge.delete();
  endtask

  task automatic push(input logic [7:0] d, input logic sof);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    @(negedge clk);
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      n_checks++;
      $display("FAIL push_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, guard);
    end else begin
      acc_edge.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic push_frame(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      push(8'(base + i), i == 0);
    end
  endtask

  task automatic push_const(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      push(v, i == 0);
    end
  endtask

  task automatic load_coef(input int idx, input logic [7:0] v);
    cfg_we   = 1'b1;
    cfg_addr = 4'(idx);
    cfg_data = v;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_all(input logic [7:0] v);
    for (int i = 0; i < 9; i++) load_coef(i, v);
  endtask

  task automatic load_identity();
    for (int i = 0; i < 9; i++) load_coef(i, (i == 4) ? 8'd16 : 8'd0);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %0b, required 1", s_ready);
    else n_pass++;
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0b, required 0", m_valid);
    else n_pass++;
    n_checks++;
    if (m_data !== 8'd0) $display("FAIL reset_m_data: got %0d, required 0", m_data);
    else n_pass++;
    n_checks++;
    if (m_eol !== 1'b0) $display("FAIL reset_m_eol: got %0b, required 0", m_eol);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_identity();
    int exp_d[4];
    int exp_e[4];
    int lat_idx[4];
    int got;
    exp_d   = '{6, 7, 10, 11};
    exp_e   = '{0, 1, 0, 1};
    lat_idx = '{10, 11, 14, 15};
    clear_logs();
    push_frame(1, 16);
    drain();
    n_checks++;
    if (out_d.size() !== 4) $display("FAIL identity_count: got %0d results, required 4", out_d.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < out_d.size()) ? out_d[i] : -1;
      n_checks++;
      if (got !== exp_d[i]) $display("FAIL identity_data[%0d]: got %0d, required %0d", i, got, exp_d[i]);
      else n_pass++;
      got = (i < out_e.size()) ? out_e[i] : -1;
      n_checks++;
      if (got !== exp_e[i]) $display("FAIL identity_eol[%0d]: got %0d, required %0d", i, got, exp_e[i]);
      else n_pass++;
      got = (i < out_c.size() && lat_idx[i] < acc_edge.size())
            ? out_c[i] - acc_edge[lat_idx[i]] : -1;
      n_checks++;
      if (got !== 2) $display("FAIL identity_latency[%0d]: got %0d edges, required 2", i, got);
      else n_pass++;
    end
  endtask

  task automatic test_box();
    int exp_d[4];
    int got;
    exp_d = '{3, 3, 5, 6};
    load_all(8'd1);
    clear_logs();
    push_frame(1, 16);
    drain();
    n_checks++;
    if (out_d.size() !== 4) $display("FAIL box_count: got %0d results, required 4", out_d.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < out_d.size()) ? out_d[i] : -1;
      n_checks++;
      if (got !== exp_d[i]) $display("FAIL box_data[%0d]: got %0d, required %0d", i, got, exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int got;
    load_all(8'd127);
    clear_logs();
    push_const(8'd255, 12);
    drain();
    n_checks++;
    if (out_d.size() !== 2) $display("FAIL sat_hi_count: got %0d results, required 2", out_d.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      got = (i < out_d.size()) ? out_d[i] : -1;
      n_checks++;
      if (got !== 255) $display("FAIL sat_hi_data[%0d]: got %0d, required 255", i, got);
      else n_pass++;
    end
    load_all(8'hFF);
    clear_logs();
    push_const(8'd200, 12);
    drain();
    n_checks++;
    if (out_d.size() !== 2) $display("FAIL sat_lo_count: got %0d results, required 2", out_d.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      got = (i < out_d.size()) ? out_d[i] : -1;
      n_checks++;
      if (got !== 0) $display("FAIL sat_lo_data[%0d]: got %0d, required 0", i, got);
      else n_pass++;
    end
  endtask

  // Drops m_ready for five edges while the second result (7, end of row) waits.
  task automatic stall_five();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!m_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!m_valid) begin
      n_checks++;
      $display("FAIL stall_wait: m_valid=%0b after %0d cycles, required 1", m_valid, guard);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'd7 || m_eol !== 1'b1)
        $display("FAIL stall_hold[%0d]: s_ready=%0b m_valid=%0b m_data=%0d m_eol=%0b, required 0 1 7 1",
                 k, s_ready, m_valid, m_data, m_eol);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
  endtask

  task automatic test_back_pressure();
    int exp_d[4];
    int exp_e[4];
    int got;
    exp_d = '{6, 7, 10, 11};
    exp_e = '{0, 1, 0, 1};
    load_identity();
    clear_logs();
    fork
      push_frame(1, 16);
      stall_five();
    join
    drain();
    n_checks++;
    if (out_d.size() !== 4) $display("FAIL bp_count: got %0d results, required 4", out_d.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < out_d.size()) ? out_d[i] : -1;
      n_checks++;
      if (got !== exp_d[i]) $display("FAIL bp_data[%0d]: got %0d, required %0d", i, got, exp_d[i]);
      else n_pass++;
      got = (i < out_e.size()) ? out_e[i] : -1;
      n_checks++;
      if (got !== exp_e[i]) $display("FAIL bp_eol[%0d]: got %0d, required %0d", i, got, exp_e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sof_restart();
    int exp_d[4];
    int got;
    exp_d = '{26, 27, 30, 31};
    clear_logs();
    push_frame(1, 10);
    push_frame(21, 16);
    drain();
    n_checks++;
    if (out_d.size() !== 4) $display("FAIL sof_count: got %0d results, required 4", out_d.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < out_d.size()) ? out_d[i] : -1;
      n_checks++;
      if (got !== exp_d[i]) $display("FAIL sof_data[%0d]: got %0d, required %0d", i, got, exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midframe();
    int exp_d[4];
    int exp_e[4];
    int got;
    exp_d = '{6, 7, 10, 11};
    exp_e = '{0, 1, 0, 1};
    load_all(8'd1);
    clear_logs();
    push_frame(1, 12);
    @(posedge clk);
    #1;
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'd3)
      $display("FAIL prereset_result: m_valid=%0b m_data=%0d, required 1 3", m_valid, m_data);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL async_m_valid: got %0b, required 0", m_valid);
    else n_pass++;
    n_checks++;
    if (m_data !== 8'd0) $display("FAIL async_m_data: got %0d, required 0", m_data);
    else n_pass++;
    n_checks++;
    if (m_eol !== 1'b0) $display("FAIL async_m_eol: got %0b, required 0", m_eol);
    else n_pass++;
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL async_s_ready: got %0b, required 1", s_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    push_frame(1, 16);
    drain();
    n_checks++;
    if (out_d.size() !== 4) $display("FAIL postreset_count: got %0d results, required 4", out_d.size());
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      got = (i < out_d.size()) ? out_d[i] : -1;
      n_checks++;
      if (got !== exp_d[i]) $display("FAIL postreset_data[%0d]: got %0d, required %0d", i, got, exp_d[i]);
      else n_pass++;
      got = (i < out_e.size()) ? out_e[i] : -1;
      n_checks++;
      if (got !== exp_e[i]) $display("FAIL postreset_eol[%0d]: got %0d, required %0d", i, got, exp_e[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_box();
    test_saturation();
    test_back_pressure();
    test_sof_restart();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
